// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer driving the register file and ALU.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module cpu_control_unit #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_valid,
  input  logic [15:0]         imem_rdata,
  output logic [3:0]          rf_raddr1,
  output logic [3:0]          rf_raddr2,
  output logic                rf_we,
  output logic [3:0]          rf_waddr,
  output logic [15:0]         rf_wdata,
  output logic [3:0]          alu_code,
  input  logic [15:0]         alu_accum,
  input  logic                alu_pc_branch,
  output logic                halted,
  output logic                illegal_op,
  output logic [15:0]         retired_count
);

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_HALT = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_ADD  = 4'b1000;
  localparam logic [3:0] OP_BLT  = 4'b1101;
  localparam logic [3:0] OP_BGT  = 4'b1110;
  localparam logic [3:0] OP_BEQ  = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t              state_reg;
  logic [PC_WIDTH-1:0] pc_reg;
  logic [15:0]         ir_reg;
  logic [3:0]          opcode;
  logic                is_alu;
  logic                is_branch;
  logic                is_legal;
  logic [PC_WIDTH-1:0] pc_seq;
  logic [PC_WIDTH-1:0] pc_target;

  assign opcode    = ir_reg[15:12];
  assign is_alu    = (opcode == OP_ADD) || (opcode == OP_SUB);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BLT) || (opcode == OP_BGT);
  assign is_legal  = is_alu || is_branch || (opcode == OP_NOP) || (opcode == OP_HALT);

  // Branch offset is a signed 4-bit field relative to the following instruction.
  assign pc_seq    = pc_reg + PC_WIDTH'(1);
  assign pc_target = pc_seq + {{(PC_WIDTH-4){ir_reg[3]}}, ir_reg[3:0]};

  assign imem_addr = pc_reg;
  assign rf_waddr  = ir_reg[11:8];
  assign rf_wdata  = alu_accum;

  always_comb begin
    rf_raddr1 = 4'd0;
    rf_raddr2 = 4'd0;
    if (is_alu) begin
      rf_raddr1 = ir_reg[7:4];
      rf_raddr2 = ir_reg[3:0];
    end else if (is_branch) begin
      rf_raddr1 = ir_reg[11:8];
      rf_raddr2 = ir_reg[7:4];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      pc_reg     <= '0;
      ir_reg     <= 16'd0;
      alu_code   <= 4'd0;
      imem_req   <= 1'b0;
      rf_we      <= 1'b0;
      halted     <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (run) begin
            state_reg <= S_FETCH;
            imem_req  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_valid) begin
            ir_reg    <= imem_rdata;
            imem_req  <= 1'b0;
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          alu_code   <= (is_alu || is_branch) ? opcode : 4'd0;
          rf_we      <= is_alu;
          illegal_op <= !is_legal;
          state_reg  <= S_EXEC;
        end
        S_EXEC: begin
          alu_code   <= 4'd0;
          rf_we      <= 1'b0;
          illegal_op <= 1'b0;
          if (opcode == OP_HALT) begin
            halted    <= 1'b1;
            state_reg <= S_HALT;
          end else begin
            pc_reg    <= (is_branch && alu_pc_branch) ? pc_target : pc_seq;
            imem_req  <= 1'b1;
            state_reg <= S_FETCH;
          end
        end
        S_HALT: begin
          state_reg <= S_HALT;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

`ifdef INSTR_COUNT_EN
  logic [15:0] retired_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_reg <= 16'd0;
    end else if (state_reg == S_EXEC) begin
      retired_reg <= retired_reg + 16'd1;
    end
  end

  assign retired_count = retired_reg;
`else
  assign retired_count = 16'd0;
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: directed test-plan steps plus random
// instruction streams, each checked against an instruction-level reference model.
module tb_cpu_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = 16'd0;
  logic [3:0]  rf_raddr1;
  logic [3:0]  rf_raddr2;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [3:0]  alu_code;
  logic [15:0] alu_accum = 16'd0;
  logic        alu_pc_branch = 1'b0;
  logic        halted;
  logic        illegal_op;
  logic [15:0] retired_count;

  int vectors = 0;
  int miscompares = 0;
  int model_pc = 0;
  int model_retired = 0;

  cpu_control_unit #(.PC_WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .run(run),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_valid(imem_valid),
    .imem_rdata(imem_rdata),
    .rf_raddr1(rf_raddr1),
    .rf_raddr2(rf_raddr2),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .alu_code(alu_code),
    .alu_accum(alu_accum),
    .alu_pc_branch(alu_pc_branch),
    .halted(halted),
    .illegal_op(illegal_op),
    .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_retired();
`ifdef INSTR_COUNT_EN
    return model_retired & 16'hFFFF;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1 reset = 1'b1;
    run = 1'b0;
    imem_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    model_pc = 0;
    model_retired = 0;
  endtask

  // Enter FETCH from IDLE; leaves the bench at posedge+1 with the first FETCH cycle visible.
  task automatic start_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  // One full instruction. Entry/exit: posedge+1 of a FETCH cycle (or HALT on exit).
  task automatic do_instr(input logic [15:0] ins, input int waits,
                          input logic [15:0] accum, input logic br);
    logic [3:0] op;
    bit alu_op, br_op, legal;
    int off, exp_a1, exp_a2;
    op = ins[15:12];
    alu_op = (op == 4'd8) || (op == 4'd4);
    br_op  = (op == 4'd15) || (op == 4'd13) || (op == 4'd14);
    legal  = alu_op || br_op || (op == 4'd0) || (op == 4'd1);
    exp_a1 = alu_op ? int'(ins[7:4]) : br_op ? int'(ins[11:8]) : 0;
    exp_a2 = alu_op ? int'(ins[3:0]) : br_op ? int'(ins[7:4]) : 0;
    off    = (ins[3:0] >= 4'd8) ? int'(ins[3:0]) - 16 : int'(ins[3:0]);

    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, model_pc);
    imem_valid = 1'b0;
    for (int w = 0; w < waits; w++) begin
      tick();
      check("stall_req", imem_req, 1);
      check("stall_addr", imem_addr, model_pc);
      check("stall_we", rf_we, 0);
    end
    imem_valid = 1'b1;
    imem_rdata = ins;
    tick();
    // DECODE: stray valid must be ignored
    imem_valid = 1'($urandom);
    imem_rdata = 16'($urandom);
    check("dec_req", imem_req, 0);
    check("dec_code", alu_code, 0);
    alu_accum = accum;
    alu_pc_branch = br;
    tick();
    check("ex_code", alu_code, (alu_op || br_op) ? op : 0);
    check("ex_we", rf_we, alu_op);
    check("ex_ill", illegal_op, !legal);
    check("ex_ra1", rf_raddr1, exp_a1);
    check("ex_ra2", rf_raddr2, exp_a2);
    if (alu_op) begin
      check("ex_waddr", rf_waddr, ins[11:8]);
      check("ex_wdata", rf_wdata, accum);
    end
    $display("instr pc=%02h ins=%04h br=%0d accum=%04h", model_pc, ins, br, accum);
    model_retired++;
    if (op != 4'd1) begin
      if (br_op && br) model_pc = (model_pc + 1 + off) & 8'hFF;
      else model_pc = (model_pc + 1) & 8'hFF;
    end
    tick();
    imem_valid = 1'b0;
    check("post_we", rf_we, 0);
    check("post_code", alu_code, 0);
    check("post_ill", illegal_op, 0);
    check("post_halt", halted, (op == 4'd1));
    check("retired", retired_count, exp_retired());
  endtask

  function automatic logic [15:0] rand_non_halt();
    logic [15:0] v;
    v = 16'($urandom);
    if (v[15:12] == 4'd1) v[15:12] = 4'd8;
    return v;
  endfunction

  initial begin
    do_reset();
    check("rst_req", imem_req, 0);
    check("rst_we", rf_we, 0);
    check("rst_halt", halted, 0);
    check("rst_ill", illegal_op, 0);
    check("rst_code", alu_code, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_ret", retired_count, 0);
    tick();
    check("idle_req", imem_req, 0);

    // Fetch + writeback, valid already high in first FETCH cycle
    start_run();
    do_instr(16'h8312, 0, 16'h0030, 1'b1);
    check("wb_pc", imem_addr, 1);

    // Fetch stall of 3 cycles
    do_instr(16'h4567, 3, 16'($urandom), 1'($urandom));

    // Random non-halt instruction stream
    for (int i = 0; i < 40; i++)
      do_instr(rand_non_halt(), $urandom_range(0, 3), 16'($urandom), 1'($urandom));

    // BEQ at pc 5, taken then not taken
    do_reset();
    start_run();
    for (int i = 0; i < 5; i++) do_instr(16'h0000, 0, 16'd0, 1'($urandom));
    do_instr(16'hF12E, 1, 16'($urandom), 1'b1);
    check("beq_taken", imem_addr, 4);
    do_instr(16'h0000, 0, 16'd0, 1'b1);
    do_instr(16'hF12E, 0, 16'($urandom), 1'b0);
    check("beq_not_taken", imem_addr, 6);

    // Branch target wrap from 0xFF
    while (model_pc != 8'hFF) do_instr(16'h0000, 0, 16'd0, 1'b1);
    do_instr(16'hE123, 0, 16'($urandom), 1'b1);
    check("bgt_wrap", imem_addr, 3);

    // Illegal then HALT
    do_reset();
    start_run();
    do_instr(16'h3ABC, 0, 16'($urandom), 1'b1);
    check("ill_pc", imem_addr, 1);
    do_instr(16'h1000, 2, 16'($urandom), 1'b1);
    check("halt_ret", retired_count, exp_retired());
    run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("halt_req", imem_req, 0);
      check("halt_flag", halted, 1);
      check("halt_pc", imem_addr, 1);
      tick();
    end
    run = 1'b0;

    // Asynchronous reset mid-EXEC of an ADD
    do_reset();
    start_run();
    imem_valid = 1'b1;
    imem_rdata = 16'h8123;
    tick();
    imem_valid = 1'b0;
    tick();
    check("pre_rst_we", rf_we, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_we", rf_we, 0);
    check("arst_req", imem_req, 0);
    check("arst_code", alu_code, 0);
    check("arst_pc", imem_addr, 0);
    @(posedge clk);
    #2 reset = 1'b0;
    model_pc = 0;
    model_retired = 0;
    tick();
    tick();
    check("arst_idle", imem_req, 0);
    start_run();
    do_instr(rand_non_halt(), $urandom_range(0, 2), 16'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Multi-cycle instruction sequencer that drives the ALU interface (alu_code, register read addresses) and consumes its results (accum, pc_branch).
- Fetches 16-bit instructions over a req/valid handshake, decodes them, and issues register-file read and write controls.
- Updates the PC sequentially or by taken branch.
- Sits between instruction memory, the register file and the ALU.

Parameters:
- PC_WIDTH, 8, width of PC and imem_addr; all PC arithmetic is modulo 2^PC_WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  leave IDLE and begin fetching
- imem_req  out  1  fetch request; high for the whole FETCH state
- imem_addr  out  PC_WIDTH  fetch address, equal to pc
- imem_valid  in  1  instruction data valid
- imem_rdata  in  16  instruction word
- rf_raddr1  out  4  register read address 1, feeds ALU reg_data1
- rf_raddr2  out  4  register read address 2, feeds ALU reg_data2
- rf_we  out  1  register write enable
- rf_waddr  out  4  register write address
- rf_wdata  out  16  register write data
- alu_code  out  4  ALU operation code
- alu_accum  in  16  ALU result
- alu_pc_branch  in  1  ALU branch-condition result
- halted  out  1  high while in HALT
- illegal_op  out  1  one-cycle pulse on an undefined opcode
- retired_count  out  16  retired-instruction counter (see Optional Feature)

Behaviour:
- Instruction register ir[15:0]; opcode = ir[15:12].
- ADD = 1000, SUB = 0100: rd = ir[11:8], rs1 = ir[7:4], rs2 = ir[3:0].
- BEQ = 1111, BLT = 1101, BGT = 1110: rs1 = ir[11:8], rs2 = ir[7:4], off = ir[3:0], a signed 4-bit value.
- NOP = 0000, HALT = 0001. All other opcodes are illegal and execute as NOP.
- Read address mapping:
  - ALU ops: rf_raddr1 = ir[7:4], rf_raddr2 = ir[3:0].
  - Branches: rf_raddr1 = ir[11:8], rf_raddr2 = ir[7:4].
  - Otherwise both are 0. These are combinational from ir.
- rf_waddr = ir[11:8]. rf_wdata = alu_accum, combinational passthrough.
- States: IDLE, FETCH, DECODE, EXEC, HALT.
  - IDLE: all control outputs low. Go to FETCH when run = 1; stay otherwise.
  - FETCH: imem_req = 1, imem_addr = pc, both stable until accepted. A fetch completes on the edge where imem_req && imem_valid; imem_valid may already be high in the first FETCH cycle. On that edge ir <= imem_rdata and the state goes to DECODE. imem_valid seen outside FETCH is ignored.
  - DECODE: one cycle. On exit, the registered alu_code loads: opcode for ALU and branch ops, 0000 otherwise.
  - EXEC: one cycle. The ALU is combinational, so alu_accum and alu_pc_branch are valid in this cycle. Actions:
    - rf_we = 1 only for ADD/SUB.
    - illegal_op = 1 for an undefined opcode.
    - At the closing edge:
      - alu_code <= 0.
      - HALT opcode: go to HALT with pc unchanged.
      - Branch with alu_pc_branch = 1: pc <= pc + 1 + sext(off).
      - Everything else: pc <= pc + 1. alu_pc_branch is ignored for non-branch opcodes.
    - Then go to FETCH.
  - HALT: halted = 1, imem_req = 0. Stays in HALT until reset; run is ignored.
- Throughput: fetch wait cycles (at least 1) + 2 cycles per instruction. alu_code is nonzero only during EXEC.
- Reset values, applied immediately with no clock edge:
  - state = IDLE, pc = 0, ir = 0, alu_code = 0, retired_count = 0.
  - imem_req = 0, rf_we = 0, halted = 0, illegal_op = 0.
- Reset asserted mid-fetch or mid-EXEC aborts the instruction: no write, no PC update.
- PC wrap: increments and branch targets wrap silently modulo 2^PC_WIDTH.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- Defined: retired_count increments by 1 (wrapping at 16 bits) at every EXEC closing edge, including NOP, illegal and HALT. It is cleared by reset.
- Undefined: retired_count is tied to 0 and no counter logic is present.

Test Plan:
- Fetch and writeback: reset, then run = 1; imem returns 0x8312 with imem_valid high in the first FETCH cycle; alu_accum = 0x0030. Required: alu_code = 1000 in EXEC, rf_raddr1 = 1, rf_raddr2 = 2, rf_we high for exactly 1 cycle with rf_waddr = 3 and rf_wdata = 0x0030; pc 0 -> 1; the next imem_req follows 3 cycles after the first.
- Fetch stall: imem_valid delayed 3 cycles. Required: imem_req and imem_addr held stable for 4 cycles; ir loaded only on the valid edge; no rf_we during the stall.
- BEQ at pc = 5: instruction 0xF12E (off = -2). With alu_pc_branch = 1, pc -> 4. On a rerun with alu_pc_branch = 0, pc -> 6. rf_we stays 0 in both cases.
- Branch wrap: PC_WIDTH = 8, pc = 0xFF, BGT with off = +3 taken. Required: pc -> 0x03.
- Halt and illegal opcode:
  - 0x3ABC: illegal_op pulses 1 cycle, no write, pc + 1.
  - 0x1000 next: halted = 1, imem_req stays 0 for 20 cycles, pc unchanged.
  - With INSTR_COUNT_EN defined, retired_count = 2.
- Asynchronous reset in EXEC of an ADD: reset raised mid-cycle. Required: rf_we, imem_req and alu_code drop without a clock edge; pc = 0; state IDLE until run.
